// File: rtl/wisc_cache_pkg.sv
// Shared definitions for the direct-mapped write-through cache controller:
// FSM state encoding and the address-field width helpers.
package wisc_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Word-offset field width (address bit 0 selects a byte and is not part of it).
  function automatic int off_width(input int line_words);
    return $clog2(line_words);
  endfunction

  // Set-index field width.
  function automatic int idx_width(input int num_sets);
    return $clog2(num_sets);
  endfunction

  // Tag takes every address bit above index, offset and the byte bit.
  function automatic int tag_width(input int addr_w, input int line_words, input int num_sets);
    return addr_w - 1 - off_width(line_words) - idx_width(num_sets);
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Cache storage: per-set valid bit and tag, plus the data words of each line.
// Reads are combinational; one word write port and one tag/valid write port,
// both synchronous. Only the valid bits are reset.
module cache_line_array #(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 8,
  parameter int DATA_W     = 16,
  parameter int TAG_W      = 8,
  parameter int IDX_W      = 4,
  parameter int OFF_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_off,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              tv_wr_en,
  input  logic [IDX_W-1:0]  tv_idx,
  input  logic [TAG_W-1:0]  tv_tag
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] valid_d;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [DATA_W-1:0]   data_q [NUM_SETS][LINE_WORDS];

  // A set becomes valid only when its tag is written at the end of a fill.
  always_comb begin
    valid_d = valid_q;
    if (tv_wr_en) valid_d[tv_idx] = 1'b1;
  end

  // Valid bits: the only storage that needs a known state after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag and data arrays: plain synchronous writes, no reset.
  always_ff @(posedge clk) begin
    if (wr_en)    data_q[wr_idx][wr_off] <= wr_data;
    if (tv_wr_en) tag_q[tv_idx]          <= tv_tag;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-through, write-allocate cache controller.
// A miss stalls the CPU, streams one read per cycle for the whole line, then
// waits for the remaining returns before marking the line valid; the held
// request then completes as a hit.
module cache_ctrl_dm
  import wisc_cache_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LINE_WORDS = 8,
  parameter int NUM_SETS   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       miss_count
);

  localparam int OFF_W = off_width(LINE_WORDS);
  localparam int IDX_W = idx_width(NUM_SETS);
  localparam int TAG_W = tag_width(ADDR_W, LINE_WORDS, NUM_SETS);
  localparam int LB_W  = TAG_W + IDX_W;
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(LINE_WORDS - 1);

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [OFF_W-1:0]  recv_cnt_q, recv_cnt_d;
  logic [LB_W-1:0]   line_base_q, line_base_d;
  logic [15:0]       miss_count_q, miss_count_d;

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              hit;
  logic              fill_active;
  logic              fill_done;

  logic              arr_wr_en;
  logic [IDX_W-1:0]  arr_wr_idx;
  logic [OFF_W-1:0]  arr_wr_off;
  logic [DATA_W-1:0] arr_wr_data;

  // Byte-select bit of the CPU address has no role in a word-wide cache.
  logic unused_byte_sel;
  assign unused_byte_sel = req_addr[0];

  assign req_off  = req_addr[OFF_W:1];
  assign req_idx  = req_addr[OFF_W+IDX_W:OFF_W+1];
  assign req_tag  = req_addr[ADDR_W-1:OFF_W+IDX_W+1];
  assign fill_idx = line_base_q[IDX_W-1:0];
  assign fill_tag = line_base_q[LB_W-1:IDX_W];

  assign hit         = req_valid & rd_valid & (rd_tag == req_tag);
  assign fill_active = (state_q == ST_FILL) || (state_q == ST_DRAIN);
  // The last return can only land in DRAIN: it trails its command by at least a cycle.
  assign fill_done   = (state_q == ST_DRAIN) && mem_rvalid && (recv_cnt_q == OFF_LAST);

  // Word write port: fill returns while filling, otherwise an IDLE store hit.
  always_comb begin
    arr_wr_en   = 1'b0;
    arr_wr_idx  = req_idx;
    arr_wr_off  = req_off;
    arr_wr_data = req_wdata;
    if (fill_active) begin
      arr_wr_en   = mem_rvalid;
      arr_wr_idx  = fill_idx;
      arr_wr_off  = recv_cnt_q;
      arr_wr_data = mem_rdata;
    end else if (state_q == ST_IDLE) begin
      arr_wr_en = hit & req_wr;
    end
  end

  cache_line_array #(
    .NUM_SETS  (NUM_SETS),
    .LINE_WORDS(LINE_WORDS),
    .DATA_W    (DATA_W),
    .TAG_W     (TAG_W),
    .IDX_W     (IDX_W),
    .OFF_W     (OFF_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (req_idx),
    .rd_off  (req_off),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (arr_wr_en),
    .wr_idx  (arr_wr_idx),
    .wr_off  (arr_wr_off),
    .wr_data (arr_wr_data),
    .tv_wr_en(fill_done),
    .tv_idx  (fill_idx),
    .tv_tag  (fill_tag)
  );

  // State register and fill bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      issue_cnt_q  <= '0;
      recv_cnt_q   <= '0;
      line_base_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      recv_cnt_q   <= recv_cnt_d;
      line_base_q  <= line_base_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Next-state: start a fill on a miss, issue every read, then drain returns.
  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    recv_cnt_d   = recv_cnt_q;
    line_base_d  = line_base_q;
    miss_count_d = miss_count_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && !hit) begin
          state_d     = ST_FILL;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          line_base_d = {req_tag, req_idx};
          if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
        end
      end
      ST_FILL: begin
        issue_cnt_d = issue_cnt_q + OFF_W'(1);
        if (issue_cnt_q == OFF_LAST) state_d = ST_DRAIN;
        if (mem_rvalid) recv_cnt_d = recv_cnt_q + OFF_W'(1);
      end
      ST_DRAIN: begin
        if (mem_rvalid) begin
          recv_cnt_d = recv_cnt_q + OFF_W'(1);
          if (recv_cnt_q == OFF_LAST) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: hit service in IDLE, read commands in FILL, all held at zero in reset.
  always_comb begin
    rdata     = '0;
    stall     = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (!hit) begin
              stall = 1'b1;
            end else if (req_wr) begin
              mem_en    = 1'b1;
              mem_wr    = 1'b1;
              mem_addr  = req_addr;
              mem_wdata = req_wdata;
            end else begin
              rdata = rd_data;
            end
          end
        end
        ST_FILL: begin
          stall    = 1'b1;
          mem_en   = 1'b1;
          mem_addr = {line_base_q, issue_cnt_q, 1'b0};
        end
        ST_DRAIN: stall = 1'b1;
        default: ;
      endcase
    end
  end

  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_cache_ctrl_dm.sv
module tb_cache_ctrl_dm;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [15:0] rdata;
  logic        stall;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic [15:0] miss_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cache_ctrl_dm dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rdata     (rdata),
    .stall     (stall),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .miss_count(miss_count)
  );

  // Backing memory contents before any store reaches it.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    logic [15:0] w;
    w = {a[15:1], 1'b0};
    if (w >= 16'h0020 && w <= 16'h002E) return 16'h00A0 + 16'((w - 16'h0020) >> 1);
    return w ^ 16'h5A5A;
  endfunction

  // Backing memory: writes land at the edge, reads return 4 cycles after the command.
  logic [15:0] mem [int];
  logic [3:0]  pv = '0;
  logic [15:0] pd [4];

  function automatic logic [15:0] mem_lookup(input logic [15:0] a);
    int k;
    k = int'(a[15:1]);
    if (mem.exists(k)) return mem[k];
    return init_val(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_wr) mem[int'(mem_addr[15:1])] = mem_wdata;
    pv    <= {pv[2:0], mem_en & ~mem_wr};
    pd[0] <= mem_lookup(mem_addr);
    for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
  end

  assign mem_rvalid = pv[3];
  assign mem_rdata  = pv[3] ? pd[3] : 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        miss;
    logic [15:0] rdata;
    logic [15:0] mc;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] sb_rdata[$];
  logic [15:0] sb_raddr[$];

  // Present one request and hold it until the DUT stops stalling.
  task automatic do_access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic miss, input logic [15:0] exp_rdata, input logic [15:0] exp_mc);
    int  stalls;
    bit  done;
    logic [15:0] e;
    stalls = 0;
    done   = 0;
    sb_raddr.delete();
    if (miss)
      for (int k = 0; k < 8; k++) sb_raddr.push_back({addr[15:4], 3'(k), 1'b0});
    if (!wr) sb_rdata.push_back(exp_rdata);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (stall) begin
        stalls++;
        if (mem_en) begin
          if (sb_raddr.size() == 0) begin
            chk("extra_read", 32'(mem_addr), 32'hFFFFFFFF);
          end else begin
            e = sb_raddr.pop_front();
            chk("fill_rd_addr", 32'(mem_addr), 32'(e));
            chk("fill_rd_wr", 32'(mem_wr), 32'd0);
          end
        end
      end else begin
        done = 1;
      end
    end
    chk("timeout", 32'(done), 32'd1);
    chk("stall_cycles", 32'(stalls), miss ? 32'd13 : 32'd0);
    chk("reads_left", 32'(sb_raddr.size()), 32'd0);
    if (wr) begin
      chk("st_mem_en", 32'(mem_en), 32'd1);
      chk("st_mem_wr", 32'(mem_wr), 32'd1);
      chk("st_mem_addr", 32'(mem_addr), 32'(addr));
      chk("st_mem_wdata", 32'(mem_wdata), 32'(wdata));
    end else begin
      chk("ld_mem_en", 32'(mem_en), 32'd0);
      if (sb_rdata.size() != 0) chk("ld_rdata", 32'(rdata), 32'(sb_rdata.pop_front()));
    end
    chk("miss_count", 32'(miss_count), 32'(exp_mc));
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("idle_mem_en", 32'(mem_en), 32'd0);
    chk("idle_stall", 32'(stall), 32'd0);
  endtask

  function automatic vec_t mk(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                              input logic miss, input logic [15:0] rd, input logic [15:0] mc);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.miss = miss; v.rdata = rd; v.mc = mc;
    return v;
  endfunction

  initial begin
    vecs.push_back(mk(1'b0, 16'h0024, 16'h0000, 1'b1, 16'h00A2, 16'd1));
    vecs.push_back(mk(1'b0, 16'h002E, 16'h0000, 1'b0, 16'h00A7, 16'd1));
    vecs.push_back(mk(1'b1, 16'h0026, 16'h1234, 1'b0, 16'h0000, 16'd1));
    vecs.push_back(mk(1'b0, 16'h0026, 16'h0000, 1'b0, 16'h1234, 16'd1));
    vecs.push_back(mk(1'b0, 16'h1024, 16'h0000, 1'b1, init_val(16'h1024), 16'd2));
    vecs.push_back(mk(1'b0, 16'h0024, 16'h0000, 1'b1, 16'h00A2, 16'd3));
    vecs.push_back(mk(1'b0, 16'h0025, 16'h0000, 1'b0, 16'h00A2, 16'd3));
    vecs.push_back(mk(1'b0, 16'h0026, 16'h0000, 1'b0, 16'h1234, 16'd3));
    vecs.push_back(mk(1'b1, 16'h0300, 16'h5555, 1'b1, 16'h0000, 16'd4));
    vecs.push_back(mk(1'b0, 16'h0300, 16'h0000, 1'b0, 16'h5555, 16'd4));
    vecs.push_back(mk(1'b0, 16'h030E, 16'h0000, 1'b0, init_val(16'h030E), 16'd4));
    vecs.push_back(mk(1'b0, 16'h1026, 16'h0000, 1'b1, init_val(16'h1026), 16'd5));

    rst       = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_miss_count", 32'(miss_count), 32'd0);
    // Outputs stay forced even with a request present during reset.
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 16'h0024;
    req_wdata = 16'hBEEF;
    #1;
    chk("rst_req_stall", 32'(stall), 32'd0);
    chk("rst_req_mem_en", 32'(mem_en), 32'd0);
    chk("rst_req_mem_wdata", 32'(mem_wdata), 32'd0);
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_wdata = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i])
      do_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].miss, vecs[i].rdata, vecs[i].mc);

    // Reset in the middle of DRAIN for a fill of 0x0040.
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 16'h0040;
    repeat (11) @(negedge clk);
    chk("drain_stall", 32'(stall), 32'd1);
    chk("drain_mem_en", 32'(mem_en), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_rdata", 32'(rdata), 32'd0);
    chk("mid_rst_miss_count", 32'(miss_count), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    // Stale returns from the abandoned fill arrive while idle.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("post_rst_mem_en", 32'(mem_en), 32'd0);
    end
    do_access(1'b0, 16'h0040, 16'h0000, 1'b1, init_val(16'h0040), 16'd1);
    do_access(1'b0, 16'h004C, 16'h0000, 1'b0, init_val(16'h004C), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_dm.md
CACHE_CTRL_DM -- requirements
Module: cache_ctrl_dm

Interface
REQ-001: Parameter ADDR_W, default 16, byte-address width.
REQ-002: Parameter DATA_W, default 16, word width; words are 2-byte aligned and addr bit 0 is ignored.
REQ-003: Parameter LINE_WORDS, default 8, words per line; must be a power of two, 2 or more.
REQ-004: Parameter NUM_SETS, default 16, direct-mapped sets; must be a power of two.
REQ-005: clk  in  1  single clock; all state updates on rising edge.
REQ-006: rst  in  1  reset, asynchronous, active-high.
REQ-007: req_valid  in  1  CPU access request.
REQ-008: req_wr  in  1  1 = store, 0 = load.
REQ-009: req_addr  in  ADDR_W  CPU byte address.
REQ-010: req_wdata  in  DATA_W  store data.
REQ-011: rdata  out  DATA_W  load data, valid when req_valid & ~req_wr & ~stall.
REQ-012: stall  out  1  CPU must hold req_* stable while high.
REQ-013: mem_en  out  1  backing-memory command strobe.
REQ-014: mem_wr  out  1  1 = write command.
REQ-015: mem_addr  out  ADDR_W  backing-memory byte address.
REQ-016: mem_wdata  out  DATA_W  write data.
REQ-017: mem_rvalid  in  1  read-return strobe; one per read command, in order, at least 1 cycle after the command.
REQ-018: mem_rdata  in  DATA_W  read-return data.
REQ-019: miss_count  out  16  saturating miss counter.

Function
REQ-020: Address split: offset = addr[log2(LINE_WORDS):1]; index = next log2(NUM_SETS) bits; tag = remaining upper bits.
REQ-021: hit = req_valid & valid[index] & (tag_array[index] == tag), evaluated combinationally.
REQ-022: FSM has three states: IDLE, FILL, DRAIN.
REQ-023: IDLE and load hit: rdata = cached word, same cycle; stall = 0.
REQ-024: IDLE and store hit: cached word updated at the clock edge; same cycle mem_en = 1, mem_wr = 1, mem_addr = req_addr, mem_wdata = req_wdata; stall = 0 (write-through).
REQ-025: IDLE and miss (load or store): stall = 1, go to FILL, zero issue_cnt and recv_cnt, capture line base address, increment miss_count unless it is 0xFFFF.
REQ-026: FILL: every cycle drive mem_en = 1, mem_wr = 0, mem_addr = {tag, index, issue_cnt, 1'b0}; increment issue_cnt.
REQ-027: FILL to DRAIN after the read with issue_cnt = LINE_WORDS-1 is issued.
REQ-028: In FILL or DRAIN, each mem_rvalid writes mem_rdata to word recv_cnt of the fill line and increments recv_cnt.
REQ-029: In DRAIN, on acceptance of the final word (recv_cnt = LINE_WORDS-1): set tag_array[index] and valid[index], go to IDLE.
REQ-030: The re-presented request then hits in IDLE; a store miss completes as a store hit (write-allocate).
REQ-031: stall = 1 throughout FILL and DRAIN, and in IDLE on a miss.
REQ-032: Load-miss stall length is LINE_WORDS + L + 1 cycles for memory latency L.
REQ-033: mem_rvalid while in IDLE is ignored, including stale returns after reset.
REQ-034: mem_en = 0 when req_valid = 0 in IDLE and in any state not listed above.
REQ-035: A fill replaces the line unconditionally; no write-back is needed because the cache is write-through.
REQ-036: The valid bit stays unchanged until the final fill word, so a partial line never hits.

Reset
REQ-037: rst clears state to IDLE, all valid bits, issue_cnt, recv_cnt and miss_count to 0.
REQ-038: rst forces stall = 0, mem_en = 0, mem_wr = 0, mem_addr = 0, mem_wdata = 0, rdata = 0.
REQ-039: Data and tag arrays need no reset.
REQ-040: Reset asserted mid-fill abandons the fill; the line stays invalid and later returns are discarded per REQ-033.

Structure
REQ-041: Shared package wisc_cache_pkg holds the FSM state encoding (IDLE = 0, FILL = 1, DRAIN = 2) and the derived offset, index and tag width functions.
REQ-042: Storage is one sub-module, cache_line_array, with valid, tag and data arrays, combinational read and one synchronous word-write port plus a tag/valid write port.

Verification
REQ-043: Memory model: reads return after L = 4 cycles. Reset, then load 0x0024 with mem[0x0020..0x002E] = 0xA0..0xA7 -> stall for 13 cycles, 8 reads to 0x0020..0x002E, then rdata = 0xA2 with stall = 0; miss_count = 1.
REQ-044: After REQ-043, load 0x002E -> rdata = 0xA7 with no stall, same cycle; miss_count stays 1.
REQ-045: Store 0x1234 to 0x0026 (hit) -> same-cycle mem write to 0x0026 with 0x1234, stall = 0; a following load of 0x0026 returns 0x1234.
REQ-046: Load 0x1024 (same index 2, tag 0x10) -> fill evicts the tag-0x00 line; then load 0x0024 -> miss again; miss_count = 3.
REQ-047: Store 0x5555 to 0x0300 (miss) -> 8-word fill, then mem write to 0x0300; a following load of 0x0300 returns 0x5555.
REQ-048: Pulse rst during DRAIN of a fill to 0x0040 -> state IDLE, late mem_rvalid ignored; next load of 0x0040 misses and refills; miss_count = 1.
